// File: rtl/spififo_top.sv
// spififo_top: SPI master sequencer and SPI slave FIFO for loopback self-test.
// The master writes eight words, reads them back through the slave and scores them.
//
// Ports:
//   refclk, rst          system clock and asynchronous active-low reset
//   com_sclk/mosi/csn    master SPI outputs (mode 0, MSB first)
//   com_miso             master SPI data input
//   slave_sclk/mosi/csn  slave SPI inputs (asynchronous to refclk)
//   slave_miso           slave SPI data output, 0 while slave_csn is high
//   sim_done/success     sticky completion flag and pass flag
//   sim_report           {mismatch_count, last_rx_word}
module spififo_top (
  input  logic        refclk,
  input  logic        rst,
  output logic        com_sclk,
  output logic        com_mosi,
  input  logic        com_miso,
  output logic        com_csn,
  input  logic        slave_sclk,
  input  logic        slave_mosi,
  output logic        slave_miso,
  input  logic        slave_csn,
  output logic        sim_success,
  output logic        sim_done,
  output logic [31:0] sim_report
);

  // ---------------- slave ----------------
  // [0],[1] form the 2-FF synchronizer; [2] is the previous value for edges.
  logic [2:0]  sck_q, csn_q;
  logic [1:0]  smo_q;
  logic [15:0] rx_q, rx_d;
  logic [4:0]  nb_q, nb_d;
  logic [15:0] tx_q, tx_d;
  logic [15:0] mem_q [8];
  logic [15:0] mem_d [8];
  logic [2:0]  wp_q, wp_d, rp_q, rp_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ovf_q, ovf_d;

  logic sck_rise, sck_fall, csn_fall, csn_rise;
  logic empty, full;

  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign csn_fall = ~csn_q[1] & csn_q[2];
  assign csn_rise = csn_q[1] & ~csn_q[2];
  assign empty    = (cnt_q == 4'd0);
  assign full     = (cnt_q == 4'd8);

  // Gate with the raw pin so MISO is 0 the moment csn goes high.
  assign slave_miso = tx_q[15] & ~csn_q[1] & ~slave_csn;

  always_comb begin
    rx_d  = rx_q;
    nb_d  = nb_q;
    tx_d  = tx_q;
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (csn_fall) begin
      nb_d = 5'd0;
      tx_d = empty ? 16'h0000 : mem_q[rp_q];
    end else if (csn_rise) begin
      tx_d = 16'h0000;
      if (nb_q == 5'd16) begin
        if (rx_q != 16'h0000) begin
          if (full) begin
            ovf_d = 1'b1;
          end else begin
            mem_d[wp_q] = rx_q;
            wp_d  = wp_q + 3'd1;
            cnt_d = cnt_q + 4'd1;
          end
        end else if (!empty) begin
          rp_d  = rp_q + 3'd1;
          cnt_d = cnt_q - 4'd1;
        end
      end
    end else if (!csn_q[1]) begin
      if (sck_rise) begin
        rx_d = {rx_q[14:0], smo_q[1]};
        // Saturate so long transactions never alias to 16.
        if (nb_q != 5'd31) nb_d = nb_q + 5'd1;
      end
      if (sck_fall) tx_d = {tx_q[14:0], 1'b0};
    end
  end

  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      sck_q <= 3'b000;
      csn_q <= 3'b111;
      smo_q <= 2'b00;
      rx_q  <= '0;
      nb_q  <= '0;
      tx_q  <= '0;
      for (int i = 0; i < 8; i++) mem_q[i] <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      sck_q <= {sck_q[1:0], slave_sclk};
      csn_q <= {csn_q[1:0], slave_csn};
      smo_q <= {smo_q[0], slave_mosi};
      rx_q  <= rx_d;
      nb_q  <= nb_d;
      tx_q  <= tx_d;
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // ---------------- master ----------------
  typedef enum logic [2:0] {
    M_IDLE, M_WAIT, M_SETUP, M_SHIFT, M_HOLD, M_GAP, M_DONE
  } mst_e;

  mst_e        st_q, st_d;
  logic [7:0]  mc_q, mc_d;
  logic [4:0]  idx_q, idx_d;
  logic [15:0] tsr_q, tsr_d;
  logic [15:0] rsr_q, rsr_d;
  logic        sclk_q, sclk_d;
  logic        mcsn_q, mcsn_d;
  logic        mosi_q, mosi_d;
  logic [15:0] mism_q, mism_d;
  logic [15:0] last_q, last_d;
  logic        done_q, done_d;
  logic        succ_q, succ_d;
  logic [15:0] word_tx, word_exp;

  // Transaction idx_q sends word_tx and expects word_exp back.
  always_comb begin
    word_tx  = 16'h0000;
    word_exp = 16'h0000;
    if (idx_q < 5'd8) word_tx = 16'hA500 + {11'd0, idx_q};
    if (idx_q >= 5'd1 && idx_q < 5'd8) word_exp = 16'hA500;
    if (idx_q >= 5'd8 && idx_q < 5'd16)
      word_exp = 16'hA500 + {11'd0, idx_q - 5'd8};
  end

  always_comb begin
    st_d   = st_q;
    mc_d   = mc_q;
    idx_d  = idx_q;
    tsr_d  = tsr_q;
    rsr_d  = rsr_q;
    sclk_d = sclk_q;
    mcsn_d = mcsn_q;
    mosi_d = mosi_q;
    mism_d = mism_q;
    last_d = last_q;
    done_d = done_q;
    succ_d = succ_q;
    unique case (st_q)
      M_IDLE: begin
        st_d = M_WAIT;
        mc_d = 8'd0;
      end
      M_WAIT, M_GAP: begin
        if ((st_q == M_WAIT && mc_q == 8'd63) ||
            (st_q == M_GAP && mc_q == 8'd15)) begin
          mc_d = 8'd0;
          if (idx_q == 5'd17) begin
            st_d   = M_DONE;
            done_d = 1'b1;
            succ_d = (mism_q == 16'd0) && !ovf_q;
          end else begin
            st_d   = M_SETUP;
            mcsn_d = 1'b0;
            tsr_d  = word_tx;
            mosi_d = word_tx[15];
          end
        end else begin
          mc_d = mc_q + 8'd1;
        end
      end
      M_SETUP: begin
        if (mc_q == 8'd3) begin
          st_d = M_SHIFT;
          mc_d = 8'd0;
        end else begin
          mc_d = mc_q + 8'd1;
        end
      end
      M_SHIFT: begin
        mc_d = mc_q + 8'd1;
        if (mc_q == 8'd127) begin
          st_d   = M_HOLD;
          mc_d   = 8'd0;
          sclk_d = 1'b0;
        end else begin
          sclk_d = mc_d[2];
          // Rising edge: capture MISO. Falling edge: present next bit.
          if (mc_q[2:0] == 3'd3) rsr_d = {rsr_q[14:0], com_miso};
          if (mc_q[2:0] == 3'd7) begin
            tsr_d  = {tsr_q[14:0], 1'b0};
            mosi_d = tsr_q[14];
          end
        end
      end
      M_HOLD: begin
        if (mc_q == 8'd3) begin
          st_d   = M_GAP;
          mc_d   = 8'd0;
          mcsn_d = 1'b1;
          mosi_d = 1'b0;
          last_d = rsr_q;
          idx_d  = idx_q + 5'd1;
          if (rsr_q != word_exp && mism_q != 16'hFFFF)
            mism_d = mism_q + 16'd1;
        end else begin
          mc_d = mc_q + 8'd1;
        end
      end
      M_DONE: begin
        st_d = M_DONE;
      end
      default: st_d = M_IDLE;
    endcase
  end

  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      st_q   <= M_IDLE;
      mc_q   <= '0;
      idx_q  <= '0;
      tsr_q  <= '0;
      rsr_q  <= '0;
      sclk_q <= 1'b0;
      mcsn_q <= 1'b1;
      mosi_q <= 1'b0;
      mism_q <= '0;
      last_q <= '0;
      done_q <= 1'b0;
      succ_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      mc_q   <= mc_d;
      idx_q  <= idx_d;
      tsr_q  <= tsr_d;
      rsr_q  <= rsr_d;
      sclk_q <= sclk_d;
      mcsn_q <= mcsn_d;
      mosi_q <= mosi_d;
      mism_q <= mism_d;
      last_q <= last_d;
      done_q <= done_d;
      succ_q <= succ_d;
    end
  end

  assign com_sclk    = sclk_q;
  assign com_csn     = mcsn_q;
  assign com_mosi    = mosi_q;
  assign sim_done    = done_q;
  assign sim_success = succ_q;
  assign sim_report  = {mism_q, last_q};

endmodule

// File: tb/tb_spififo_top.sv
// tb_spififo_top: scoreboard bench for the SPI loopback top.
// Drives loopback, forced-MISO and slave-only scenarios.
module tb_spififo_top;

  logic        clk;
  logic        rst;
  logic        com_sclk, com_mosi, com_csn;
  logic        m_miso;
  logic        s_sclk, s_mosi, s_csn;
  logic        slave_miso;
  logic        sim_success, sim_done;
  logic [31:0] sim_report;

  logic loop_en, miso_force;
  logic tb_sclk, tb_mosi, tb_csn;

  assign s_sclk = loop_en ? com_sclk : tb_sclk;
  assign s_mosi = loop_en ? com_mosi : tb_mosi;
  assign s_csn  = loop_en ? com_csn  : tb_csn;
  assign m_miso = (loop_en && !miso_force) ? slave_miso : 1'b0;

  spififo_top dut (
    .refclk      (clk),
    .rst         (rst),
    .com_sclk    (com_sclk),
    .com_mosi    (com_mosi),
    .com_miso    (m_miso),
    .com_csn     (com_csn),
    .slave_sclk  (s_sclk),
    .slave_mosi  (s_mosi),
    .slave_miso  (slave_miso),
    .slave_csn   (s_csn),
    .sim_success (sim_success),
    .sim_done    (sim_done),
    .sim_report  (sim_report)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] miso;
    logic [15:0] mosi;
    bit          chk_mosi;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] model_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference for the built-in sequence: a plain 8-deep queue.
  task automatic predict_loop();
    logic [15:0] m[$];
    logic [15:0] w;
    exp_t        e;
    for (int i = 0; i < 17; i++) begin
      w = (i < 8) ? 16'hA500 + 16'(i) : 16'h0000;
      e.miso = (m.size() > 0) ? m[0] : 16'h0000;
      e.mosi = w;
      e.chk_mosi = 1'b1;
      exp_q.push_back(e);
      if (w != 16'h0000) begin
        if (m.size() < 8) m.push_back(w);
      end else if (m.size() > 0) begin
        void'(m.pop_front());
      end
    end
  endtask

  // Bench-driven SPI transaction on the slave pins.
  task automatic xfer(input logic [15:0] w, input int nb);
    logic [15:0] sh;
    exp_t        e;
    if (nb == 16) begin
      e.miso = (model_q.size() > 0) ? model_q[0] : 16'h0000;
      e.mosi = w;
      e.chk_mosi = 1'b0;
      exp_q.push_back(e);
      if (w != 16'h0000) begin
        if (model_q.size() < 8) model_q.push_back(w);
      end else if (model_q.size() > 0) begin
        void'(model_q.pop_front());
      end
    end
    sh = w;
    tb_csn = 1'b0;
    tb_mosi = sh[15];
    tick(4);
    for (int b = 0; b < nb; b++) begin
      tb_sclk = 1'b1;
      tick(4);
      tb_sclk = 1'b0;
      sh = {sh[14:0], 1'b0};
      tb_mosi = sh[15];
      tick(4);
    end
    tb_csn = 1'b1;
    tb_mosi = 1'b0;
    tick(16);
  endtask

  // Monitor: decode each slave-pin transaction and score full words.
  initial begin : monitor
    logic        pc, ps;
    int          nb;
    logic [15:0] mi, mo;
    exp_t        e;
    pc = 1'b1;
    ps = 1'b0;
    nb = 0;
    mi = '0;
    mo = '0;
    forever begin
      @(negedge clk);
      if (pc && !s_csn) nb = 0;
      if (!s_csn && !ps && s_sclk) begin
        mi = {mi[14:0], slave_miso};
        mo = {mo[14:0], s_mosi};
        nb++;
      end
      if (!pc && s_csn && nb == 16) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", {16'h0, mi}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("miso_word", {16'h0, mi}, {16'h0, e.miso});
          if (e.chk_mosi) chk("mosi_word", {16'h0, mo}, {16'h0, e.mosi});
        end
      end
      pc = s_csn;
      ps = s_sclk;
    end
  end

  task automatic wait_done(input string nm, output int cyc);
    cyc = 0;
    for (int c = 0; c < 4000 && !sim_done; c++) begin
      tick(1);
      cyc = c + 1;
    end
    chk(nm, {31'd0, sim_done}, 32'd1);
  endtask

  initial begin : stim
    int bad;
    int cyc;
    int op;
    int nbits;
    logic [15:0] d;
    rst = 1'b0;
    loop_en = 1'b1;
    miso_force = 1'b0;
    tb_sclk = 1'b0;
    tb_mosi = 1'b0;
    tb_csn = 1'b1;
    tick(2);

    // Reset held low: bus must stay idle.
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (com_sclk !== 1'b0 || com_csn !== 1'b1) bad++;
      tick(1);
    end
    chk("rst_bus_idle", bad, 0);
    chk("rst_csn", {31'd0, com_csn}, 32'd1);
    chk("rst_sclk", {31'd0, com_sclk}, 32'd0);
    chk("rst_mosi", {31'd0, com_mosi}, 32'd0);
    chk("rst_smiso", {31'd0, slave_miso}, 32'd0);
    chk("rst_done", {31'd0, sim_done}, 32'd0);
    chk("rst_success", {31'd0, sim_success}, 32'd0);
    chk("rst_report", sim_report, 32'd0);

    // Reset asserted during the first transaction.
    rst = 1'b1;
    tick($urandom_range(100, 180));
    chk("pre_midrst_csn", {31'd0, com_csn}, 32'd0);
    rst = 1'b0;
    #1;
    chk("midrst_csn", {31'd0, com_csn}, 32'd1);
    chk("midrst_sclk", {31'd0, com_sclk}, 32'd0);
    chk("midrst_report", sim_report, 32'd0);
    tick(5);

    // Full loopback run.
    predict_loop();
    rst = 1'b1;
    wait_done("loop_done", cyc);
    chk("loop_latency", {31'd0, (cyc >= 2600 && cyc <= 2700)}, 32'd1);
    chk("loop_success", {31'd0, sim_success}, 32'd1);
    chk("loop_report", sim_report, 32'd0);
    chk("loop_words_left", exp_q.size(), 0);
    tick(200);
    chk("loop_idle_csn", {31'd0, com_csn}, 32'd1);
    chk("loop_done_sticky", {31'd0, sim_done}, 32'd1);

    // Master MISO forced low; slave still answers on its own pins.
    rst = 1'b0;
    tick(2);
    exp_q.delete();
    miso_force = 1'b1;
    predict_loop();
    rst = 1'b1;
    wait_done("force_done", cyc);
    chk("force_success", {31'd0, sim_success}, 32'd0);
    chk("force_mismatch", {16'd0, sim_report[31:16]}, 32'd15);
    chk("force_last", {16'd0, sim_report[15:0]}, 32'd0);
    chk("force_words_left", exp_q.size(), 0);

    // Slave driven directly by the bench.
    rst = 1'b0;
    tick(2);
    exp_q.delete();
    model_q.delete();
    loop_en = 1'b0;
    miso_force = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(5);
    for (int i = 0; i < 9; i++) xfer(16'($urandom_range(1, 16'hFFFF)), 16);
    for (int i = 0; i < 9; i++) xfer(16'h0000, 16);
    xfer(16'h1234, 16);
    xfer(16'h5678, 16);
    xfer(16'h9ABC, 10);
    xfer(16'h0000, 10);
    xfer(16'h0000, 16);
    xfer(16'h0000, 16);
    xfer(16'h0000, 16);
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 3);
      d = 16'($urandom_range(1, 16'hFFFF));
      nbits = $urandom_range(1, 17);
      if (nbits == 16) nbits = 15;
      case (op)
        0, 1: xfer(d, 16);
        2: xfer(16'h0000, 16);
        default: xfer((op == 3 && nbits[0]) ? 16'h0000 : d, nbits);
      endcase
    end
    tick(10);
    chk("slave_words_left", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
